// File: rtl/stream_reg_responder_if.sv
// Byte-stream and register-bus bundle between stream_reg_responder and its environment.
// The responder sits on the master side; usb_serial and the register file sit on the slave side.
interface stream_reg_responder_if;
   logic       rx_tvalid;
   logic       rx_tready;
   logic [7:0] rx_tdata;
   logic       tx_tvalid;
   logic       tx_tready;
   logic [7:0] tx_tdata;
   logic       reg_wr;
   logic       reg_rd;
   logic [7:0] reg_addr;
   logic [7:0] reg_wdata;
   logic [7:0] reg_rdata;

   modport master (
      input  rx_tvalid, rx_tdata, tx_tready, reg_rdata,
      output rx_tready, tx_tvalid, tx_tdata, reg_wr, reg_rd, reg_addr, reg_wdata
   );

   modport slave (
      output rx_tvalid, rx_tdata, tx_tready, reg_rdata,
      input  rx_tready, tx_tvalid, tx_tdata, reg_wr, reg_rd, reg_addr, reg_wdata
   );
endinterface

// File: rtl/stream_reg_responder.sv
// ASCII line-command front end for an 8-bit register bus: "Raa" reads, "Waadd" writes,
// each line answered with hex data, "OK" or "ER" followed by the configured line ending.
module stream_reg_responder #(
   parameter int RD_LATENCY = 1,
   parameter int EOL_CR     = 1
) (
   input logic                    clk,
   input logic                    rstn,
   stream_reg_responder_if.master bus
);
   typedef enum logic [2:0] {IDLE, ARG, DISCARD, EXEC, RDWAIT, RESP} state_t;

   localparam logic [2:0] LAT      = 3'(RD_LATENCY);
   localparam logic [2:0] RESP_LEN = (EOL_CR != 0) ? 3'd4 : 3'd3;

   state_t      state_q;
   logic        isWrite_q;
   logic [2:0]  nibCnt_q;
   logic [15:0] arg_q;
   logic [31:0] respBuf_q;
   logic [2:0]  respLen_q;
   logic [2:0]  latCnt_q;
   logic        txValid_q;
   logic        regWr_q;
   logic        regRd_q;
   logic [7:0]  regAddr_q;
   logic [7:0]  regWdata_q;

   logic [7:0] rxByte;
   logic       rxReady, rxFire, txFire;
   logic       isCr, isLf, isDigit, isHex, isW, isCmd;
   logic [3:0] hexVal;

   function automatic logic [7:0] hexChar(input logic [3:0] n);
      return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
   endfunction

   // Response is left-aligned in the buffer; byte 0 always leaves first.
   function automatic logic [31:0] buildResp(input logic [7:0] a, input logic [7:0] b);
      return (EOL_CR != 0) ? {a, b, 8'h0D, 8'h0A} : {a, b, 8'h0A, 8'h00};
   endfunction

   assign rxByte  = bus.rx_tdata;
   assign isCr    = (rxByte == 8'h0D);
   assign isLf    = (rxByte == 8'h0A);
   assign isDigit = (rxByte >= 8'h30) && (rxByte <= 8'h39);
   assign isHex   = isDigit || ((rxByte >= 8'h41) && (rxByte <= 8'h46))
                            || ((rxByte >= 8'h61) && (rxByte <= 8'h66));
   assign hexVal  = isDigit ? rxByte[3:0] : (rxByte[3:0] + 4'd9);
   assign isW     = (rxByte == 8'h57) || (rxByte == 8'h77);
   assign isCmd   = isW || (rxByte == 8'h52) || (rxByte == 8'h72);
   assign rxReady = (state_q == IDLE) || (state_q == ARG) || (state_q == DISCARD);
   assign rxFire  = bus.rx_tvalid && rxReady;
   assign txFire  = txValid_q && bus.tx_tready;

   assign bus.rx_tready = rxReady;
   assign bus.tx_tvalid = txValid_q;
   assign bus.tx_tdata  = respBuf_q[31:24];
   assign bus.reg_wr    = regWr_q;
   assign bus.reg_rd    = regRd_q;
   assign bus.reg_addr  = regAddr_q;
   assign bus.reg_wdata = regWdata_q;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= IDLE;
         isWrite_q  <= 1'b0;
         nibCnt_q   <= '0;
         arg_q      <= '0;
         respBuf_q  <= '0;
         respLen_q  <= '0;
         latCnt_q   <= '0;
         txValid_q  <= 1'b0;
         regWr_q    <= 1'b0;
         regRd_q    <= 1'b0;
         regAddr_q  <= '0;
         regWdata_q <= '0;
      end else begin
         regWr_q <= 1'b0;
         regRd_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (rxFire && !isCr && !isLf) begin
                  if (isCmd) begin
                     isWrite_q <= isW;
                     nibCnt_q  <= '0;
                     arg_q     <= '0;
                     state_q   <= ARG;
                  end else begin
                     state_q <= DISCARD;
                  end
               end
            end
            ARG: begin
               if (rxFire && !isCr) begin
                  if (isLf) begin
                     // Strobes are raised here so they are high exactly during EXEC.
                     if (isWrite_q && nibCnt_q == 3'd4) begin
                        regWr_q    <= 1'b1;
                        regAddr_q  <= arg_q[15:8];
                        regWdata_q <= arg_q[7:0];
                        state_q    <= EXEC;
                     end else if (!isWrite_q && nibCnt_q == 3'd2) begin
                        regRd_q   <= 1'b1;
                        regAddr_q <= arg_q[7:0];
                        state_q   <= EXEC;
                     end else begin
                        respBuf_q <= buildResp(8'h45, 8'h52);
                        respLen_q <= RESP_LEN;
                        txValid_q <= 1'b1;
                        state_q   <= RESP;
                     end
                  end else if (isHex && nibCnt_q != 3'd4) begin
                     arg_q    <= {arg_q[11:0], hexVal};
                     nibCnt_q <= nibCnt_q + 3'd1;
                  end else begin
                     state_q <= DISCARD;
                  end
               end
            end
            DISCARD: begin
               if (rxFire && isLf) begin
                  respBuf_q <= buildResp(8'h45, 8'h52);
                  respLen_q <= RESP_LEN;
                  txValid_q <= 1'b1;
                  state_q   <= RESP;
               end
            end
            EXEC: begin
               if (isWrite_q) begin
                  respBuf_q <= buildResp(8'h4F, 8'h4B);
                  respLen_q <= RESP_LEN;
                  txValid_q <= 1'b1;
                  state_q   <= RESP;
               end else begin
                  latCnt_q <= 3'd1;
                  state_q  <= RDWAIT;
               end
            end
            RDWAIT: begin
               if (latCnt_q == LAT) begin
                  respBuf_q <= buildResp(hexChar(bus.reg_rdata[7:4]), hexChar(bus.reg_rdata[3:0]));
                  respLen_q <= RESP_LEN;
                  txValid_q <= 1'b1;
                  state_q   <= RESP;
               end else begin
                  latCnt_q <= latCnt_q + 3'd1;
               end
            end
            RESP: begin
               if (txFire) begin
                  if (respLen_q == 3'd1) begin
                     txValid_q <= 1'b0;
                     state_q   <= IDLE;
                  end else begin
                     respBuf_q <= {respBuf_q[23:0], 8'h00};
                     respLen_q <= respLen_q - 3'd1;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_stream_reg_responder.sv
// Scoreboard bench for stream_reg_responder: dutA uses RD_LATENCY=3 with CR/LF endings,
// dutB uses RD_LATENCY=1 with LF-only endings.
module tb_stream_reg_responder;
   logic clk = 1'b0;
   logic rstn;
   always #5 clk = ~clk;

   stream_reg_responder_if ifA ();
   stream_reg_responder_if ifB ();

   stream_reg_responder #(.RD_LATENCY(3), .EOL_CR(1)) dutA (.clk(clk), .rstn(rstn), .bus(ifA));
   stream_reg_responder #(.RD_LATENCY(1), .EOL_CR(0)) dutB (.clk(clk), .rstn(rstn), .bus(ifB));

   int checks = 0;
   int errors = 0;

   logic [7:0] expA[$];
   logic [7:0] expB[$];
   int         delivered[2];
   int         wrCnt[2];
   int         rdCnt[2];
   logic [7:0] lastAddr[2];
   logic [7:0] lastWdata[2];
   logic       prevStall[2];
   logic [7:0] prevData[2];
   logic       prevStrobe[2];

   // Register file model: data is only correct exactly RD_LATENCY cycles after reg_rd.
   logic [7:0] rdValA, rdValB;
   int         rdAgeA, rdAgeB;
   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rdAgeA <= 0;
         rdAgeB <= 0;
      end else begin
         if (ifA.reg_rd) rdAgeA <= 1;
         else if (rdAgeA != 0 && rdAgeA < 7) rdAgeA <= rdAgeA + 1;
         if (ifB.reg_rd) rdAgeB <= 1;
         else if (rdAgeB != 0 && rdAgeB < 7) rdAgeB <= rdAgeB + 1;
      end
   end
   assign ifA.reg_rdata = (rdAgeA == 3) ? rdValA : 8'hEE;
   assign ifB.reg_rdata = (rdAgeB == 1) ? rdValB : 8'hEE;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
      end
   endtask

   function automatic int qSize(input int id);
      return (id == 0) ? expA.size() : expB.size();
   endfunction

   function automatic logic rxr(input int id);
      return (id == 0) ? ifA.rx_tready : ifB.rx_tready;
   endfunction

   task automatic pushExp(input int id, input string s);
      for (int i = 0; i < s.len(); i++) begin
         if (id == 0) expA.push_back(s[i]);
         else expB.push_back(s[i]);
      end
   endtask

   task automatic setReady(input int id, input logic v);
      if (id == 0) ifA.tx_tready = v;
      else ifB.tx_tready = v;
   endtask

   task automatic monitorBus(input int id, input logic tv, input logic tr, input logic [7:0] td,
                             input logic rxReady, input logic wr, input logic rd,
                             input logic [7:0] addr, input logic [7:0] wdata);
      logic [7:0] exp;
      if (!rstn) begin
         prevStall[id]  = 1'b0;
         prevStrobe[id] = 1'b0;
      end else begin
         if (prevStall[id]) checkOutput("txHold", 32'({tv, td}), 32'({1'b1, prevData[id]}));
         if (tv) checkOutput("rxReadyResp", 32'(rxReady), 32'(0));
         if (tv && tr) begin
            if (qSize(id) == 0) begin
               checkOutput("txExtra", 32'(td), 32'hFFFF);
            end else begin
               if (id == 0) exp = expA.pop_front();
               else exp = expB.pop_front();
               checkOutput("txByte", 32'(td), 32'(exp));
               delivered[id]++;
            end
         end
         prevStall[id] = tv && !tr;
         prevData[id]  = td;
         if (wr || rd) begin
            checkOutput("strobeExcl", 32'(wr && rd), 32'(0));
            checkOutput("strobeWidth", 32'(prevStrobe[id]), 32'(0));
            if (wr) begin
               wrCnt[id]++;
               lastWdata[id] = wdata;
            end
            if (rd) rdCnt[id]++;
            lastAddr[id] = addr;
         end
         prevStrobe[id] = wr || rd;
      end
   endtask

   always @(negedge clk) monitorBus(0, ifA.tx_tvalid, ifA.tx_tready, ifA.tx_tdata, ifA.rx_tready,
                                    ifA.reg_wr, ifA.reg_rd, ifA.reg_addr, ifA.reg_wdata);
   always @(negedge clk) monitorBus(1, ifB.tx_tvalid, ifB.tx_tready, ifB.tx_tdata, ifB.rx_tready,
                                    ifB.reg_wr, ifB.reg_rd, ifB.reg_addr, ifB.reg_wdata);

   task automatic applyStimulus(input int id, input string s);
      logic accepted;
      int   n;
      for (int i = 0; i < s.len(); i++) begin
         if (id == 0) begin ifA.rx_tvalid = 1'b1; ifA.rx_tdata = s[i]; end
         else begin ifB.rx_tvalid = 1'b1; ifB.rx_tdata = s[i]; end
         accepted = 1'b0;
         n = 0;
         while (!accepted && n < 50) begin
            @(negedge clk);
            accepted = rxr(id);
            @(posedge clk);
            #1;
            n++;
         end
         checkOutput("rxAccept", 32'(accepted), 32'(1));
      end
      if (id == 0) ifA.rx_tvalid = 1'b0;
      else ifB.rx_tvalid = 1'b0;
   endtask

   // Runs until the response has fully drained; first = cycle index of the first tx_tvalid.
   task automatic drainResponse(input int id, input bit stall, output int first);
      logic [3:0] pat;
      logic       tv;
      bit         done;
      int         k;
      pat   = 4'b1001;
      first = 0;
      done  = 0;
      k     = 0;
      setReady(id, stall ? pat[0] : 1'b1);
      for (int n = 1; n <= 200 && !done; n++) begin
         @(negedge clk);
         #1;
         tv = (id == 0) ? ifA.tx_tvalid : ifB.tx_tvalid;
         if (tv && first == 0) first = n;
         done = (n >= 4) && !tv && (qSize(id) == 0);
         @(posedge clk);
         #1;
         k++;
         setReady(id, stall ? pat[k % 4] : 1'b1);
      end
      setReady(id, 1'b1);
      checkOutput("drainEmpty", 32'(qSize(id)), 32'(0));
      checkOutput("idleReady", 32'(rxr(id)), 32'(1));
   endtask

   initial begin
      int    first, w0, r0, d0, n;
      string bad[3];
      bad[0] = "R1\n";
      bad[1] = "W12345\n";
      bad[2] = "X9\n";

      rstn = 1'b0;
      ifA.rx_tvalid = 1'b0; ifA.rx_tdata = 8'h00; ifA.tx_tready = 1'b1;
      ifB.rx_tvalid = 1'b0; ifB.rx_tdata = 8'h00; ifB.tx_tready = 1'b1;
      rdValA = 8'h00;
      rdValB = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rstTxValid", 32'(ifA.tx_tvalid), 32'(0));
      checkOutput("rstRxReady", 32'(ifA.rx_tready), 32'(1));
      checkOutput("rstStrobes", 32'({ifA.reg_wr, ifA.reg_rd}), 32'(0));
      checkOutput("rstAddr", 32'({ifA.reg_addr, ifA.reg_wdata, ifA.tx_tdata}), 32'(0));
      checkOutput("rstB", 32'({ifB.tx_tvalid, ifB.rx_tready}), 32'(1));
      rstn = 1'b1;
      @(posedge clk);
      #1;

      $display("[TB] write W3A5C");
      w0 = wrCnt[0]; r0 = rdCnt[0];
      pushExp(0, "OK\r\n");
      applyStimulus(0, "W3A5C\n");
      drainResponse(0, 0, first);
      checkOutput("wrLatency", first, 2);
      checkOutput("wrCount", wrCnt[0] - w0, 1);
      checkOutput("wrNoRead", rdCnt[0] - r0, 0);
      checkOutput("wrAddr", 32'(lastAddr[0]), 32'h3A);
      checkOutput("wrData", 32'(lastWdata[0]), 32'h5C);

      $display("[TB] read r3a with CR");
      rdValA = 8'hB7;
      w0 = wrCnt[0]; r0 = rdCnt[0];
      pushExp(0, "B7\r\n");
      applyStimulus(0, "r3a\r\n");
      drainResponse(0, 0, first);
      checkOutput("rdLatency", first, 5);
      checkOutput("rdCount", rdCnt[0] - r0, 1);
      checkOutput("rdNoWrite", wrCnt[0] - w0, 0);
      checkOutput("rdAddr", 32'(lastAddr[0]), 32'h3A);

      $display("[TB] malformed lines");
      for (int i = 0; i < 3; i++) begin
         w0 = wrCnt[0]; r0 = rdCnt[0];
         pushExp(0, "ER\r\n");
         applyStimulus(0, bad[i]);
         drainResponse(0, 0, first);
         checkOutput("errNoStrobe", (wrCnt[0] - w0) + (rdCnt[0] - r0), 0);
      end

      $display("[TB] empty lines");
      w0 = wrCnt[0]; r0 = rdCnt[0];
      applyStimulus(0, "\n\r\n");
      drainResponse(0, 0, first);
      checkOutput("emptyNoTx", first, 0);
      checkOutput("emptyNoStrobe", (wrCnt[0] - w0) + (rdCnt[0] - r0), 0);

      $display("[TB] read with tx_tready stalls");
      rdValA = 8'hC4;
      pushExp(0, "C4\r\n");
      applyStimulus(0, "R5E\n");
      drainResponse(0, 1, first);
      checkOutput("stallLatency", first, 5);
      checkOutput("stallAddr", 32'(lastAddr[0]), 32'h5E);

      $display("[TB] reset during response");
      w0 = wrCnt[0];
      d0 = delivered[0];
      pushExp(0, "OK");
      applyStimulus(0, "W1234\n");
      n = 0;
      while (delivered[0] < d0 + 2 && n < 100) begin
         @(negedge clk);
         #1;
         n++;
      end
      checkOutput("midDelivered", delivered[0] - d0, 2);
      @(posedge clk);
      #1;
      rstn = 1'b0;
      #1;
      checkOutput("midRstTxValid", 32'(ifA.tx_tvalid), 32'(0));
      checkOutput("midRstRxReady", 32'(ifA.rx_tready), 32'(1));
      repeat (2) @(posedge clk);
      #1;
      rstn = 1'b1;
      checkOutput("midWrCount", wrCnt[0] - w0, 1);
      checkOutput("midWrAddr", 32'({lastAddr[0], lastWdata[0]}), 32'h1234);
      rdValA = 8'h4F;
      pushExp(0, "4F\r\n");
      applyStimulus(0, "R00\n");
      drainResponse(0, 0, first);
      checkOutput("postRstLatency", first, 5);
      checkOutput("postRstAddr", 32'(lastAddr[0]), 32'h00);

      $display("[TB] LF-only endings, RD_LATENCY=1");
      w0 = wrCnt[1]; r0 = rdCnt[1];
      pushExp(1, "OK\n");
      applyStimulus(1, "W0001\n");
      drainResponse(1, 0, first);
      checkOutput("bWrLatency", first, 2);
      checkOutput("bWrCount", wrCnt[1] - w0, 1);
      checkOutput("bWrAddrData", 32'({lastAddr[1], lastWdata[1]}), 32'h0001);
      rdValB = 8'h9D;
      pushExp(1, "9D\n");
      applyStimulus(1, "R7F\n");
      drainResponse(1, 0, first);
      checkOutput("bRdLatency", first, 3);
      checkOutput("bRdCount", rdCnt[1] - r0, 1);
      checkOutput("bRdAddr", 32'(lastAddr[1]), 32'h7F);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/stream_reg_responder.md
Name: stream_reg_responder

Overview:
- Sits on the far side of the usb_serial byte-stream interface: consumes the rx stream and drives the tx stream.
- Lets a host terminal read and write an 8-bit-addressed, 8-bit-data register bus using ASCII line commands.
- Parses each line, issues one register access, and returns an ASCII response line.
- Replaces the plain loopback in the application top level.

Parameters:
- RD_LATENCY, 1, cycles from the reg_rd pulse to sampling reg_rdata; legal range 1..4.
- EOL_CR, 1, 1: responses end with 0x0D 0x0A; 0: responses end with 0x0A only.

Ports:
- clk  input  1  system clock (48 MHz domain shared with usb_serial).
- rstn  input  1  asynchronous active-low reset.
- rx_tvalid  input  1  host byte available.
- rx_tready  output  1  block accepts host byte.
- rx_tdata  input  8  host byte.
- tx_tvalid  output  1  response byte valid.
- tx_tready  input  1  usb_serial accepts response byte.
- tx_tdata  output  8  response byte.
- reg_wr  output  1  single-cycle write strobe.
- reg_rd  output  1  single-cycle read strobe.
- reg_addr  output  8  register address, held from strobe until the next command.
- reg_wdata  output  8  write data, valid with reg_wr.
- reg_rdata  input  8  read data, sampled RD_LATENCY cycles after reg_rd.

Behaviour:
- Reset (rstn low, asynchronous): state IDLE.
  - All outputs 0 except rx_tready=1.
  - Nibble count, argument shift register and response buffer cleared.
  - A partially sent response is dropped; no byte is retransmitted after reset.
- Handshakes:
  - A byte transfers only on a cycle where valid and ready are both high.
  - tx_tvalid/tx_tdata stay stable until tx_tready; tvalid is never retracted.
  - rx_tready=1 only in IDLE, ARG and DISCARD.
- Character classes:
  - 0x0D is ignored in every receiving state.
  - 0x0A is the terminator.
  - Hex digits are 0-9, A-F, a-f.
  - Command letters are R/r and W/w.
- IDLE:
  - 0x0A: no response (empty line), stay IDLE.
  - Command letter: latch op, clear nibble count, go to ARG.
  - Any other byte: go to DISCARD.
- ARG:
  - Hex digit: shift into a 16-bit argument register (left shift by 4), count++.
  - A 5th digit or a non-hex byte other than the terminator: go to DISCARD.
  - 0x0A: valid if R has exactly 2 digits or W has exactly 4 digits, then go to EXEC; otherwise queue error, go to RESP.
- DISCARD: swallow bytes until 0x0A, then queue error, go to RESP.
- EXEC, one cycle:
  - W: reg_addr=arg[15:8], reg_wdata=arg[7:0], reg_wr=1; queue "OK"+EOL; go to RESP.
  - R: reg_addr=arg[7:0], reg_rd=1; go to RDWAIT.
- RDWAIT:
  - Count RD_LATENCY cycles, then sample reg_rdata.
  - Queue two uppercase hex chars (high nibble first)+EOL; go to RESP.
- RESP:
  - Shift out the queued bytes (max 4).
  - Error response is "ER"+EOL.
  - EOL is 2 bytes if EOL_CR=1, else 1 byte.
  - Return to IDLE the cycle after the last byte's handshake.
  - rx_tready=0 throughout; host bytes back-pressure and are not lost.
- Latency:
  - The first response byte asserts tx_tvalid the cycle after EXEC (write/error) or after sampling (read).
  - With tx_tready held high, one byte transfers per cycle.
- Strobes: reg_wr and reg_rd are exactly one cycle wide; never both high; at most one per line.

Test Plan:
- "W3A5C\n", tx_tready=1 → one reg_wr pulse with addr=0x3A, wdata=0x5C; tx bytes 'O','K',0x0D,0x0A; rx_tready low during the response.
- "r3a\r\n", reg_rdata=0xB7, RD_LATENCY=3 → reg_rd with addr=0x3A; rdata sampled 3 cycles later; tx 'B','7',0x0D,0x0A; CR ignored.
- "R1\n", "W12345\n" and "X9\n" → each produces "ER\r\n"; no reg_wr/reg_rd pulse.
- "\n\r\n" → no tx activity; state stays IDLE.
- Read response with tx_tready toggling 1-0-0-1 → tx_tdata/tvalid stable while stalled; all 4 bytes delivered in order once each.
- rstn asserted after the second byte of "OK\r\n" → tx_tvalid=0 immediately; then "R00\n" → clean response with no stale bytes.
- EOL_CR=0 with "W0001\n" → tx 'O','K',0x0A only.
